// File: rtl/lab2_proc_fetch_drop_buf.sv
// lab2_proc_fetch_drop_buf: 2-entry in-order buffer between imem responses and
// the D stage, able to squash the oldest undelivered fetch response.
// Squashes that arrive before their response are remembered in drop_pend.
// Optional zero-latency bypass: define LAB2_PROC_FETCH_DROP_BYPASS_EN.
module lab2_proc_fetch_drop_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in_msg,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_msg,
    input  logic        drop,
    output logic [1:0]  count,
    output logic [1:0]  drop_pend,
    output logic        drop_ovf
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;

    logic [DATA_W-1:0] q [DEPTH];
    logic              head;
    logic              tail;

    logic              q_nz;
    logic              pend_nz;
    logic              pass_ok;
    logic              in_fire;
    logic              out_fire;
    logic              discard;
    logic              enq;
    logic              deq;
    logic              ovf_set;
    logic [1:0]        pend_next;

    // Handshake, output selection and squash bookkeeping for this cycle
    always_comb begin
        q_nz      = (count != 2'd0);
        pend_nz   = (drop_pend != 2'd0);
        in_rdy    = (count < 2'(DEPTH)) | pend_nz;
`ifdef LAB2_PROC_FETCH_DROP_BYPASS_EN
        pass_ok   = !q_nz & !pend_nz & !drop;
        out_val   = q_nz ? !drop : (pass_ok & in_val);
        out_msg   = q_nz ? q[head] : in_msg;
`else
        pass_ok   = 1'b0;
        out_val   = q_nz & !drop;
        out_msg   = q[head];
`endif
        in_fire   = in_val & in_rdy;
        out_fire  = out_val & out_rdy;
        discard   = 1'b0;
        deq       = 1'b0;
        ovf_set   = 1'b0;
        pend_next = drop_pend;

        if (drop) begin
            if (q_nz) begin
                // Oldest undelivered word is the queue head
                deq = 1'b1;
            end else if (in_val && !pend_nz) begin
                // Oldest undelivered word is the one arriving now
                discard = 1'b1;
            end else if (in_fire) begin
                // Arriving word pays off an older drop; this drop takes its place
                discard = 1'b1;
            end else if (drop_pend == 2'd3) begin
                ovf_set = 1'b1;
            end else begin
                pend_next = drop_pend + 2'd1;
            end
        end else begin
            deq = out_fire & q_nz;
            if (in_fire && pend_nz) begin
                discard   = 1'b1;
                pend_next = drop_pend - 2'd1;
            end
        end

        // A bypassed word that is taken this cycle never enters the queue
        enq = in_fire & !discard & !(pass_ok & out_fire & !q_nz);
    end

    // Queue storage; data needs no reset since count gates its visibility
    always_ff @(posedge clk) begin
        if (enq) begin
            q[tail] <= in_msg;
        end
    end

    // Pointer, occupancy and pending-drop state
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            drop_pend <= 2'd0;
            drop_ovf  <= 1'b0;
        end else begin
            if (enq) begin
                tail <= ~tail;
            end
            if (deq) begin
                head <= ~head;
            end
            count     <= count + 2'(enq) - 2'(deq);
            drop_pend <= pend_next;
            if (ovf_set) begin
                drop_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: doc/lab2_proc_fetch_drop_buf.md
LAB2_PROC_FETCH_DROP_BUF -- requirements
Module: lab2_proc_fetch_drop_buf

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_val  input  1  imem response valid.
REQ-004 SHALL have port: in_rdy  output  1  block accepts imem response.
REQ-005 SHALL have port: in_msg  input  32  imem response data (instruction word).
REQ-006 SHALL have port: out_val  output  1  instruction valid toward D stage.
REQ-007 SHALL have port: out_rdy  input  1  D stage accepts instruction.
REQ-008 SHALL have port: out_msg  output  32  instruction toward D stage.
REQ-009 SHALL have port: drop  input  1  squash the oldest undelivered fetch response.
REQ-010 SHALL have port: count  output  2  queue occupancy, 0..2.
REQ-011 SHALL have port: drop_pend  output  2  pending drops for not-yet-arrived responses, 0..3.
REQ-012 SHALL have port: drop_ovf  output  1  sticky: a drop was lost to saturation.

Function
REQ-013 SHALL hold a 2-entry in-order queue of 32-bit words with a head pointer, tail pointer and count.
REQ-014 SHALL define in fire = in_val & in_rdy and out fire = out_val & out_rdy.
REQ-015 SHALL drive in_rdy = (count < 2) | (drop_pend != 0); no pass-through when full, even if out fires in the same cycle.
REQ-016 SHALL, when in fires with drop_pend != 0 and drop = 0, discard in_msg (no enqueue, no output) and decrement drop_pend.
REQ-017 SHALL apply drop to the oldest undelivered response, in priority order: (a) count != 0: dequeue and discard head; (b) count == 0 and in_val = 1 and drop_pend == 0: accept and discard in_msg; (c) otherwise increment drop_pend.
REQ-018 SHALL, in case (c) with in_val = 1 and drop_pend != 0, discard the arriving word and leave drop_pend unchanged (one drop consumed, one added).
REQ-019 SHALL, in case (c) with drop_pend == 3 and no word arriving, leave drop_pend at 3 and set drop_ovf.
REQ-020 SHALL force out_val = 0 in any cycle drop = 1.
REQ-021 SHALL enqueue a fired input that is not discarded at the tail; out fire SHALL dequeue head; simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-022 SHALL wrap head/tail pointers modulo 2.
REQ-023 SHALL drive out_msg = head entry when count != 0; out_msg is don't-care when out_val = 0.
REQ-024 SHALL keep out_val/out_msg stable while out_val = 1 and out_rdy = 0, unless drop = 1.

Reset
REQ-025 SHALL, on reset = 1 at a clock edge, clear count, pointers, drop_pend and drop_ovf to 0, discarding any queued words and pending drops, regardless of other inputs that cycle.
REQ-026 SHALL drive out_val = 0 and in_rdy = 1 in the cycle after reset is sampled.

Configuration
REQ-027 SHALL support macro LAB2_PROC_FETCH_DROP_BYPASS_EN.
REQ-028 With the macro defined, when count == 0, drop_pend == 0 and drop = 0: out_val = in_val and out_msg = in_msg; if out_rdy = 1 the word SHALL pass through without being enqueued (zero latency). If out_rdy = 0, it SHALL be enqueued.
REQ-029 Without the macro, out_val = (count != 0) & !drop; every delivered word incurs exactly one cycle of queue latency.

Verification
REQ-030 Stream: in words 0x00000013, 0x00100093 with out_rdy = 1 -> delivered in order; 1-cycle latency without macro, same-cycle with macro.
REQ-031 Backpressure: out_rdy = 0, send 3 words -> count = 2 and in_rdy = 0 after second; release -> all three delivered in order, none lost.
REQ-032 Drop of queued head: count = 2 holding 0xA, 0xB, drop = 1 -> out_val = 0 that cycle; next cycle count = 1 and out_msg = 0xB.
REQ-033 Early drop: drop pulsed 2 cycles with empty queue and in_val = 0 -> drop_pend = 2; next words 0x1, 0x2, 0x3 arrive -> only 0x3 delivered, drop_pend returns to 0.
REQ-034 Saturation: 4 drops with nothing arriving -> drop_pend = 3, drop_ovf = 1; reset -> both 0.
REQ-035 Reset mid-operation: count = 2, drop_pend = 1, assert reset -> next cycle count = 0, out_val = 0, in_rdy = 1; following word delivered normally.
